// File: rtl/taxi_dma_ram_demux_pkg.sv
// rtl/taxi_dma_ram_demux_pkg.sv - shared tag type and select-width helper for the ordered RAM read demux
package taxi_dma_ram_demux_pkg;

    localparam int TAG_PORT_W = 4;

    typedef struct packed {
        logic                  err;
        logic [TAG_PORT_W-1:0] port;
    } tag_t;

    function automatic int sel_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/taxi_dma_ram_demux_tag_fifo.sv
// rtl/taxi_dma_ram_demux_tag_fifo.sv - per-segment FIFO of outstanding read tags
module taxi_dma_ram_demux_tag_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Callers only push when not full and pop when not empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/taxi_dma_ram_demux_rd_ord.sv
// rtl/taxi_dma_ram_demux_rd_ord.sv - in-order RAM read demux; TAXI_DMA_RAM_DEMUX_ERR_EN enables out-of-range error replies
module taxi_dma_ram_demux_rd_ord
    import taxi_dma_ram_demux_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int SEGS       = 2,
    parameter int SEG_ADDR_W = 10,
    parameter int SEG_DATA_W = 64,
    parameter int DEPTH      = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [SEGS*(SEG_ADDR_W+sel_w(PORTS))-1:0] s_cmd_addr,
    input  logic [SEGS-1:0]                           s_cmd_valid,
    output logic [SEGS-1:0]                           s_cmd_ready,
    output logic [SEGS*SEG_DATA_W-1:0]                s_resp_data,
    output logic [SEGS-1:0]                           s_resp_err,
    output logic [SEGS-1:0]                           s_resp_valid,
    input  logic [SEGS-1:0]                           s_resp_ready,
    output logic [PORTS*SEGS*SEG_ADDR_W-1:0]          m_cmd_addr,
    output logic [PORTS*SEGS-1:0]                     m_cmd_valid,
    input  logic [PORTS*SEGS-1:0]                     m_cmd_ready,
    input  logic [PORTS*SEGS*SEG_DATA_W-1:0]          m_resp_data,
    input  logic [PORTS*SEGS-1:0]                     m_resp_valid,
    output logic [PORTS*SEGS-1:0]                     m_resp_ready,
    output logic                                      err_flag
);
    localparam int SEL_W = sel_w(PORTS);
    localparam int S_AW  = SEG_ADDR_W + SEL_W;
`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
    localparam int FIFO_W = $bits(tag_t);
    logic [SEGS-1:0] seg_err_cmd;
`else
    localparam int FIFO_W = TAG_PORT_W;
`endif

    for (genvar s = 0; s < SEGS; s++) begin : g_seg
        logic [SEL_W-1:0]      sel_raw;
        logic [TAG_PORT_W-1:0] sel;
        logic                  bad;
        logic                  port_ready;
        logic                  full, empty, push, pop;
        logic [FIFO_W-1:0]     fifo_din, fifo_dout;
        tag_t                  head;
        logic [PORTS-1:0]      cmd_valid, resp_ready;
        logic                  head_valid;
        logic [SEG_DATA_W-1:0] head_data;
        logic                  beat_in, stall, load_skid, load_from_skid, load_from_head;
        logic                  out_valid, skid_valid;
        logic [SEG_DATA_W-1:0] out_data, skid_data;

        assign sel_raw = s_cmd_addr[s*S_AW+SEG_ADDR_W +: SEL_W];

        always_comb begin
            sel = TAG_PORT_W'(sel_raw);
            bad = 1'b0;
            if (int'(sel_raw) >= PORTS) begin
`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
                bad = 1'b1;
`else
                sel = TAG_PORT_W'(PORTS-1);
`endif
            end
        end

        always_comb begin
            cmd_valid  = '0;
            port_ready = bad;
            for (int p = 0; p < PORTS; p++) begin
                if (sel == TAG_PORT_W'(p)) begin
                    cmd_valid[p] = rst_n & s_cmd_valid[s] & ~full & ~bad;
                    port_ready   = port_ready | m_cmd_ready[p*SEGS+s];
                end
            end
        end

        assign s_cmd_ready[s] = rst_n & ~full & port_ready;
        assign push           = s_cmd_valid[s] & s_cmd_ready[s];

`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
        assign fifo_din       = {bad, sel};
        assign head           = fifo_dout;
        assign seg_err_cmd[s] = push & bad;
`else
        assign fifo_din = sel;
        assign head     = '{err: 1'b0, port: fifo_dout};
`endif

        taxi_dma_ram_demux_tag_fifo #(.W(FIFO_W), .DEPTH(DEPTH)) u_tag_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push),
            .din   (fifo_din),
            .pop   (pop),
            .dout  (fifo_dout),
            .full  (full),
            .empty (empty)
        );

        // Only the head port may hand over data; marker tags reply with zero data
        always_comb begin
            resp_ready = '0;
            head_valid = 1'b0;
            head_data  = '0;
            for (int p = 0; p < PORTS; p++) begin
                if (head.port == TAG_PORT_W'(p)) begin
                    resp_ready[p] = rst_n & ~empty & ~skid_valid & ~head.err;
                    head_valid    = m_resp_valid[p*SEGS+s];
                    head_data     = m_resp_data[(p*SEGS+s)*SEG_DATA_W +: SEG_DATA_W];
                end
            end
            if (head.err) begin
                head_valid = 1'b1;
                head_data  = '0;
            end
        end

        assign beat_in        = ~empty & ~skid_valid & head_valid;
        assign pop            = beat_in;
        assign stall          = out_valid & ~s_resp_ready[s];
        assign load_skid      = stall & beat_in;
        assign load_from_skid = ~stall & skid_valid;
        assign load_from_head = ~stall & ~skid_valid & beat_in;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid  <= 1'b0;
                out_data   <= '0;
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else begin
                if (load_skid) begin
                    skid_valid <= 1'b1;
                    skid_data  <= head_data;
                end else if (load_from_skid) begin
                    skid_valid <= 1'b0;
                end
                if (load_from_skid) begin
                    out_data <= skid_data;
                end else if (load_from_head) begin
                    out_data <= head_data;
                end
                if (!stall) out_valid <= skid_valid | beat_in;
            end
        end

`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
        logic out_err, skid_err;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_err  <= 1'b0;
                skid_err <= 1'b0;
            end else begin
                if (load_skid)      skid_err <= head.err;
                if (load_from_skid) out_err  <= skid_err;
                else if (load_from_head) out_err <= head.err;
            end
        end
        assign s_resp_err[s] = out_err;
`else
        assign s_resp_err[s] = 1'b0;
`endif

        assign s_resp_valid[s]                           = out_valid;
        assign s_resp_data[s*SEG_DATA_W +: SEG_DATA_W]   = out_data;

        for (genvar p = 0; p < PORTS; p++) begin : g_port
            assign m_cmd_valid[p*SEGS+s]  = cmd_valid[p];
            assign m_resp_ready[p*SEGS+s] = resp_ready[p];
            assign m_cmd_addr[(p*SEGS+s)*SEG_ADDR_W +: SEG_ADDR_W] = s_cmd_addr[s*S_AW +: SEG_ADDR_W];
        end
    end

`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            err_flag <= 1'b0;
        else if (|seg_err_cmd) err_flag <= 1'b1;
    end
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_taxi_dma_ram_demux_rd_ord.sv
// tb/tb_taxi_dma_ram_demux_rd_ord.sv - directed self-checking bench for taxi_dma_ram_demux_rd_ord
module tb_taxi_dma_ram_demux_rd_ord;
    localparam int PORTS = 4, SEGS = 2, AW = 10, DW = 64, DEPTH = 8;
    localparam logic [63:0] D0 = 64'hD0D0_0000_0000_0000, D2 = 64'hD2D2_0000_0000_0002, D3 = 64'hD3D3_0000_0000_0003;
    localparam logic [63:0] BB = 64'hBEEF_0000_0000_0000;
    localparam logic [63:0] E0 = 64'hE0E0_0000_0000_0010, E1 = 64'hE1E1_0000_0000_0011, E2 = 64'hE2E2_0000_0000_0012;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [SEGS*(AW+2)-1:0]      s_cmd_addr;
    logic [SEGS-1:0]             s_cmd_valid, s_cmd_ready, s_resp_err, s_resp_valid, s_resp_ready;
    logic [SEGS*DW-1:0]          s_resp_data;
    logic [PORTS*SEGS*AW-1:0]    m_cmd_addr;
    logic [PORTS*SEGS-1:0]       m_cmd_valid, m_cmd_ready, m_resp_valid, m_resp_ready;
    logic [PORTS*SEGS*DW-1:0]    m_resp_data;
    logic                        err_flag;

    logic [AW+1:0] c3_addr;
    logic          c3_valid, c3_ready, r3_err, r3_valid, r3_ready, ef3;
    logic [DW-1:0] r3_data;
    logic [3*AW-1:0] m3_addr;
    logic [2:0]    m3_cvalid, m3_cready, m3_rvalid, m3_rready;
    logic [3*DW-1:0] m3_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    taxi_dma_ram_demux_rd_ord #(.PORTS(PORTS), .SEGS(SEGS), .SEG_ADDR_W(AW), .SEG_DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_addr(s_cmd_addr), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_resp_data(s_resp_data), .s_resp_err(s_resp_err), .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_resp_data(m_resp_data), .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .err_flag(err_flag)
    );

    taxi_dma_ram_demux_rd_ord #(.PORTS(3), .SEGS(1), .SEG_ADDR_W(AW), .SEG_DATA_W(DW), .DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_addr(c3_addr), .s_cmd_valid(c3_valid), .s_cmd_ready(c3_ready),
        .s_resp_data(r3_data), .s_resp_err(r3_err), .s_resp_valid(r3_valid), .s_resp_ready(r3_ready),
        .m_cmd_addr(m3_addr), .m_cmd_valid(m3_cvalid), .m_cmd_ready(m3_cready),
        .m_resp_data(m3_rdata), .m_resp_valid(m3_rvalid), .m_resp_ready(m3_rready),
        .err_flag(ef3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_resp0(input int p, input logic v, input logic [63:0] d);
        m_resp_valid[p*SEGS] = v;
        m_resp_data[p*SEGS*DW +: DW] = d;
    endtask

    task automatic cmd0(input int sel, input logic [AW-1:0] addr);
        logic [1:0] s2;
        s2 = 2'(sel);
        s_cmd_addr[AW+1:0] = {s2, addr};
        s_cmd_valid[0] = 1'b1;
        settle;
        check("cmd_valid", m_cmd_valid, 64'(8'b1 << (sel*SEGS)));
        check("cmd_ready", s_cmd_ready[0], 1);
        check("cmd_addr", m_cmd_addr[sel*SEGS*AW +: AW], addr);
        tick;
        s_cmd_valid[0] = 1'b0;
    endtask

    task automatic cmd3(input int sel, input logic [AW-1:0] addr);
        logic [1:0] s2;
        s2 = 2'(sel);
        c3_addr = {s2, addr};
        c3_valid = 1'b1;
        settle;
        check("c3_cmd_ready", c3_ready, 1);
        check("c3_cmd_valid", m3_cvalid, 64'(3'b1 << sel));
        tick;
        c3_valid = 1'b0;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        int in_idx, out_idx;
        logic stalled, hs_in;
        logic [63:0] held;
        in_idx = 0; out_idx = 0; stalled = 1'b0; held = '0;

        rst_n = 1'b0;
        s_cmd_addr = '0; s_cmd_valid = '1; s_resp_ready = '1;
        m_cmd_ready = '1; m_resp_valid = '1; m_resp_data = '1;
        c3_addr = '0; c3_valid = 1'b0; r3_ready = 1'b1; m3_cready = '1; m3_rvalid = '0; m3_rdata = '0;
        tick;
        tick;
        check("rst_cmd_ready", s_cmd_ready, 0);
        check("rst_resp_valid", s_resp_valid, 0);
        check("rst_resp_data", s_resp_data, 0);
        check("rst_m_cmd_valid", m_cmd_valid, 0);
        check("rst_m_resp_ready", m_resp_ready, 0);
        check("rst_err_flag", err_flag, 0);
        s_cmd_valid = '0; m_resp_valid = '0; m_resp_data = '0;
        rst_n = 1'b1;
        tick;

        // in-order return: ports 2,0,3 with port 3 answering first
        cmd0(2, 10'h011);
        cmd0(0, 10'h022);
        cmd0(3, 10'h033);
        set_resp0(3, 1'b1, D3);
        settle;
        check("ord_head_ready", m_resp_ready, 8'h10);
        tick;
        check("ord_ignore_nonhead", s_resp_valid[0], 0);
        set_resp0(2, 1'b1, D2);
        tick;
        check("ord_v0", s_resp_valid[0], 1);
        check("ord_d0", s_resp_data[DW-1:0], D2);
        set_resp0(2, 1'b0, '0);
        set_resp0(0, 1'b1, D0);
        settle;
        check("ord_head_ready1", m_resp_ready, 8'h01);
        tick;
        check("ord_d1", s_resp_data[DW-1:0], D0);
        set_resp0(0, 1'b0, '0);
        settle;
        check("ord_head_ready2", m_resp_ready, 8'h40);
        tick;
        check("ord_v2", s_resp_valid[0], 1);
        check("ord_d2", s_resp_data[DW-1:0], D3);
        set_resp0(3, 1'b0, '0);
        tick;
        check("ord_drained", s_resp_valid[0], 0);
        set_resp0(3, 1'b1, D3);
        settle;
        check("empty_ignore", m_resp_ready, 0);
        tick;
        check("empty_no_beat", s_resp_valid[0], 0);
        set_resp0(3, 1'b0, '0);

        // FIFO full after DEPTH commands, other segment unaffected
        for (int i = 0; i < DEPTH; i++) cmd0(1, 10'(i));
        s_cmd_addr[AW+1:0] = {2'd1, 10'h3ff};
        s_cmd_valid[0] = 1'b1;
        s_cmd_addr[2*(AW+2)-1:AW+2] = {2'd0, 10'h005};
        s_cmd_valid[1] = 1'b1;
        set_resp0(1, 1'b1, 64'hA0);
        settle;
        check("full_ready", s_cmd_ready[0], 0);
        check("full_no_cmd", m_cmd_valid[2], 0);
        check("full_head_ready", m_resp_ready[2], 1);
        check("seg1_indep", s_cmd_ready[1], 1);
        tick;
        s_cmd_valid[1] = 1'b0;
        check("full_pop_ready", s_cmd_ready[0], 1);
        check("full_pop_data", s_resp_data[DW-1:0], 64'hA0);
        s_cmd_valid[0] = 1'b0;
        set_resp0(1, 1'b0, '0);
        reset_dut;

        // burst of 4 with a 5-cycle upstream stall
        for (int i = 0; i < 4; i++) cmd0(0, 10'(16 + i));
        for (int cyc = 0; cyc < 16; cyc++) begin
            s_resp_ready[0] = (cyc >= 5);
            set_resp0(0, in_idx < 4, BB + 64'(in_idx));
            settle;
            if (stalled) check("stall_hold", s_resp_data[DW-1:0], held);
            if (s_resp_valid[0] && s_resp_ready[0]) begin
                check("burst_data", s_resp_data[DW-1:0], BB + 64'(out_idx));
                out_idx++;
            end
            stalled = s_resp_valid[0] && !s_resp_ready[0];
            held = s_resp_data[DW-1:0];
            hs_in = m_resp_valid[0] && m_resp_ready[0];
            tick;
            if (hs_in) in_idx++;
        end
        check("burst_in_count", in_idx, 4);
        check("burst_out_count", out_idx, 4);
        check("burst_no_extra", s_resp_valid[0], 0);
        set_resp0(0, 1'b0, '0);

        // reset with reads outstanding and a beat held at the output
        cmd0(1, 10'h041);
        cmd0(2, 10'h042);
        cmd0(3, 10'h043);
        cmd0(2, 10'h044);
        s_resp_ready[0] = 1'b0;
        set_resp0(1, 1'b1, 64'hC1);
        tick;
        set_resp0(1, 1'b0, '0);
        check("pre_rst_valid", s_resp_valid[0], 1);
        s_cmd_addr[AW+1:0] = {2'd0, 10'h050};
        s_cmd_valid[0] = 1'b1;
        set_resp0(2, 1'b1, 64'hC2);
        rst_n = 1'b0;
        settle;
        check("arst_resp_valid", s_resp_valid, 0);
        check("arst_resp_data", s_resp_data[DW-1:0], 0);
        check("arst_cmd_ready", s_cmd_ready, 0);
        check("arst_m_cmd_valid", m_cmd_valid, 0);
        check("arst_m_resp_ready", m_resp_ready, 0);
        tick;
        s_cmd_valid[0] = 1'b0;
        rst_n = 1'b1;
        settle;
        check("late_resp_ignored", m_resp_ready, 0);
        tick;
        check("late_no_beat", s_resp_valid[0], 0);
        set_resp0(2, 1'b0, '0);
        s_resp_ready[0] = 1'b1;

        // out-of-range select on a 3-port instance
        cmd3(0, 10'h005);
        c3_addr = {2'd3, 10'h006};
        c3_valid = 1'b1;
        settle;
        check("c3_mid_ready", c3_ready, 1);
`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
        check("c3_mid_no_cmd", m3_cvalid, 3'b000);
`else
        check("c3_mid_clamp", m3_cvalid, 3'b100);
        check("c3_mid_addr", m3_addr[3*AW-1:2*AW], 10'h006);
`endif
        tick;
        c3_valid = 1'b0;
        cmd3(1, 10'h007);
        m3_rvalid = 3'b111;
        m3_rdata = {E2, E1, E0};
        tick;
        check("c3_r0_data", r3_data, E0);
        check("c3_r0_err", r3_err, 0);
        tick;
        check("c3_r1_valid", r3_valid, 1);
`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
        check("c3_r1_data", r3_data, 0);
        check("c3_r1_err", r3_err, 1);
`else
        check("c3_r1_data", r3_data, E2);
        check("c3_r1_err", r3_err, 0);
`endif
        tick;
        check("c3_r2_data", r3_data, E1);
        check("c3_r2_err", r3_err, 0);
        m3_rvalid = '0;
`ifdef TAXI_DMA_RAM_DEMUX_ERR_EN
        check("c3_err_flag", ef3, 1);
`else
        check("c3_err_flag", ef3, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
